// File: rtl/axis_packet_tracker.sv
// ---------------------------------------------------------------------------
// axis_packet_tracker
// Counts complete AXI-Stream packets held in each of C_NUM_CHANNELS RX FIFOs
// by watching TLAST handshakes on the write (S) and read (M) sides. Each
// channel has a saturating count, sticky overflow/underflow flags and an
// interrupt coalescer with a shared packet-count threshold and timeout.
//
// Optional build macro: PKT_TRACKER_WATERMARK_EN
//   When defined, adds the AXIS_PACKET_MAX output, which holds a high-watermark
//   of the count for each channel.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   S_AXIS_TVALID/TREADY/TLAST   FIFO write-side handshake, 1 bit per channel
//   M_AXIS_TVALID/TREADY/TLAST   FIFO read-side handshake, 1 bit per channel
//   AXIS_PACKET_COUNT    per-channel count, channel i at [i*W +: W]
//   IRQ_THRESHOLD        shared count threshold (0 behaves as 1)
//   IRQ_TIMEOUT          shared coalescing timeout in cycles (0 = no timeout)
//   ENABLE_IRQ/CLEAR_IRQ per-channel IRQ enable / clear pulse
//   IRQ, IRQ_ANY         per-channel interrupt and their OR
//   CLEAR_ERR            clears all sticky error flags
//   OVERFLOW/UNDERFLOW   sticky per-channel error flags
//   AXIS_PACKET_MAX      (watermark build only) per-channel count high-watermark
// ---------------------------------------------------------------------------
module axis_packet_tracker #(
    parameter int unsigned C_NUM_CHANNELS     = 4,
    parameter int unsigned C_DATA_COUNT_WIDTH = 11,
    parameter int unsigned C_TIMEOUT_WIDTH    = 16
) (
    input  logic                                         aclk,
    input  logic                                         aresetn,
    input  logic [C_NUM_CHANNELS-1:0]                    S_AXIS_TVALID,
    input  logic [C_NUM_CHANNELS-1:0]                    S_AXIS_TREADY,
    input  logic [C_NUM_CHANNELS-1:0]                    S_AXIS_TLAST,
    input  logic [C_NUM_CHANNELS-1:0]                    M_AXIS_TVALID,
    input  logic [C_NUM_CHANNELS-1:0]                    M_AXIS_TREADY,
    input  logic [C_NUM_CHANNELS-1:0]                    M_AXIS_TLAST,
    output logic [C_NUM_CHANNELS*C_DATA_COUNT_WIDTH-1:0] AXIS_PACKET_COUNT,
    input  logic [C_DATA_COUNT_WIDTH-1:0]                IRQ_THRESHOLD,
    input  logic [C_TIMEOUT_WIDTH-1:0]                   IRQ_TIMEOUT,
    input  logic [C_NUM_CHANNELS-1:0]                    ENABLE_IRQ,
    input  logic [C_NUM_CHANNELS-1:0]                    CLEAR_IRQ,
    output logic [C_NUM_CHANNELS-1:0]                    IRQ,
    output logic                                         IRQ_ANY,
    input  logic                                         CLEAR_ERR,
    output logic [C_NUM_CHANNELS-1:0]                    OVERFLOW,
    output logic [C_NUM_CHANNELS-1:0]                    UNDERFLOW
`ifdef PKT_TRACKER_WATERMARK_EN
    ,
    output logic [C_NUM_CHANNELS*C_DATA_COUNT_WIDTH-1:0] AXIS_PACKET_MAX
`endif
);

    localparam int unsigned NC = C_NUM_CHANNELS;
    localparam int unsigned CW = C_DATA_COUNT_WIDTH;
    localparam int unsigned TW = C_TIMEOUT_WIDTH;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_ASSERTED = 2'd2
    } irq_state_t;

    // Shared threshold/timeout decode
    logic [CW-1:0] w_thr;
    logic          w_tmo_one;
    logic          w_tmo_zero;

    assign w_thr      = (IRQ_THRESHOLD == '0) ? CW'(1) : IRQ_THRESHOLD;
    assign w_tmo_one  = (IRQ_TIMEOUT == TW'(1));
    assign w_tmo_zero = (IRQ_TIMEOUT == '0);

    logic [NC-1:0] w_irq_next;
    logic          r_irq_any;

    for (genvar g = 0; g < NC; g++) begin : g_ch
        logic          w_inc;
        logic          w_dec;
        logic [CW-1:0] w_cnt_next;
        logic          w_ovf_evt;
        logic          w_udf_evt;
        logic          w_hit_thr;
        logic          w_cnt_zero;
        logic          w_start;
        logic          w_start_assert;
        logic          w_tmo_hit;
        logic          w_irq_nxt;

        logic [CW-1:0] r_cnt;
        logic          r_ovf;
        logic          r_udf;
        irq_state_t    r_state;
        logic [TW-1:0] r_timer;
        logic          r_irq;

        assign w_inc = S_AXIS_TVALID[g] & S_AXIS_TREADY[g] & S_AXIS_TLAST[g];
        assign w_dec = M_AXIS_TVALID[g] & M_AXIS_TREADY[g] & M_AXIS_TLAST[g];

        // Saturating next count and error events
        always_comb begin
            w_cnt_next = r_cnt;
            w_ovf_evt  = 1'b0;
            w_udf_evt  = 1'b0;
            if (w_inc && !w_dec) begin
                if (r_cnt == CNT_MAX) begin
                    w_ovf_evt = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end else if (w_dec && !w_inc) begin
                if (r_cnt == '0) begin
                    w_udf_evt = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
        end

        assign w_hit_thr      = (w_cnt_next >= w_thr);
        assign w_cnt_zero     = (w_cnt_next == '0);
        assign w_start        = ENABLE_IRQ[g] & w_inc;
        assign w_start_assert = w_start & (w_hit_thr | w_tmo_one);
        assign w_tmo_hit      = ~w_tmo_zero & (r_timer == TW'(1));

        // Next-cycle IRQ bit; feeds both r_irq and the shared IRQ_ANY flop
        always_comb begin
            w_irq_nxt = 1'b0;
            case (r_state)
                ST_IDLE:     w_irq_nxt = w_start_assert;
                ST_PENDING:  w_irq_nxt = ENABLE_IRQ[g] & ~w_cnt_zero & (w_hit_thr | w_tmo_hit);
                ST_ASSERTED: w_irq_nxt = CLEAR_IRQ[g] ? w_start_assert : 1'b1;
                default:     w_irq_nxt = 1'b0;
            endcase
        end

        assign w_irq_next[g] = w_irq_nxt;

        // Packet count and sticky error flags; a new error beats CLEAR_ERR
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_evt | (r_ovf & ~CLEAR_ERR);
                r_udf <= w_udf_evt | (r_udf & ~CLEAR_ERR);
            end
        end

        // Interrupt coalescing FSM; timer counts from the first packet only
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_irq   <= 1'b0;
            end else begin
                r_irq <= w_irq_nxt;
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_assert) begin
                            r_state <= ST_ASSERTED;
                        end else if (w_start) begin
                            r_state <= ST_PENDING;
                            r_timer <= IRQ_TIMEOUT;
                        end
                    end
                    ST_PENDING: begin
                        if (!ENABLE_IRQ[g] || w_cnt_zero) begin
                            r_state <= ST_IDLE;
                        end else if (w_hit_thr || w_tmo_hit) begin
                            r_state <= ST_ASSERTED;
                        end else if (r_timer != '0) begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    ST_ASSERTED: begin
                        // Clearing re-runs the idle entry so a coincident packet is kept
                        if (CLEAR_IRQ[g]) begin
                            if (w_start_assert) begin
                                r_state <= ST_ASSERTED;
                            end else if (w_start) begin
                                r_state <= ST_PENDING;
                                r_timer <= IRQ_TIMEOUT;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end

        assign AXIS_PACKET_COUNT[g*CW +: CW] = r_cnt;
        assign IRQ[g]                        = r_irq;
        assign OVERFLOW[g]                   = r_ovf;
        assign UNDERFLOW[g]                  = r_udf;

`ifdef PKT_TRACKER_WATERMARK_EN
        logic [CW-1:0] r_max;

        // High-watermark; CLEAR_ERR restarts it from the current count
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                r_max <= '0;
            end else if (CLEAR_ERR) begin
                r_max <= w_cnt_next;
            end else if (w_cnt_next > r_max) begin
                r_max <= w_cnt_next;
            end
        end

        assign AXIS_PACKET_MAX[g*CW +: CW] = r_max;
`endif
    end

    // IRQ_ANY registered from next-state bits so it lines up with IRQ
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_irq_any <= 1'b0;
        end else begin
            r_irq_any <= |w_irq_next;
        end
    end

    assign IRQ_ANY = r_irq_any;

endmodule

// File: doc/axis_packet_tracker.md
Name: axis_packet_tracker

Overview:
- Multi-channel successor to the single-FIFO packet counter.
- Tracks how many complete AXI-Stream packets sit in each of C_NUM_CHANNELS FIFOs by watching TLAST handshakes on the FIFO write and read sides.
- Adds saturation, sticky overflow/underflow error flags, and per-channel interrupt coalescing with a packet-count threshold and a timeout.
- Sits beside the RX FIFOs; counts and IRQs feed the AXI-Lite control block.

Parameters:
- C_NUM_CHANNELS, 4, number of independent FIFO channels (1..16).
- C_DATA_COUNT_WIDTH, 11, width of each packet count.
- C_TIMEOUT_WIDTH, 16, width of the coalescing timeout.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- S_AXIS_TVALID  in  C_NUM_CHANNELS  FIFO write-side TVALID, one bit per channel
- S_AXIS_TREADY  in  C_NUM_CHANNELS  FIFO write-side TREADY
- S_AXIS_TLAST  in  C_NUM_CHANNELS  FIFO write-side TLAST
- M_AXIS_TVALID  in  C_NUM_CHANNELS  FIFO read-side TVALID
- M_AXIS_TREADY  in  C_NUM_CHANNELS  FIFO read-side TREADY
- M_AXIS_TLAST  in  C_NUM_CHANNELS  FIFO read-side TLAST
- AXIS_PACKET_COUNT  out  C_NUM_CHANNELS*C_DATA_COUNT_WIDTH  per-channel count; channel i occupies bits [i*W +: W]
- IRQ_THRESHOLD  in  C_DATA_COUNT_WIDTH  shared count threshold; 0 is treated as 1
- IRQ_TIMEOUT  in  C_TIMEOUT_WIDTH  shared coalescing timeout in cycles; 0 disables the timeout
- ENABLE_IRQ  in  C_NUM_CHANNELS  per-channel IRQ enable
- CLEAR_IRQ  in  C_NUM_CHANNELS  per-channel IRQ clear pulse
- IRQ  out  C_NUM_CHANNELS  per-channel interrupt
- IRQ_ANY  out  1  OR of IRQ
- CLEAR_ERR  in  1  clears all sticky error flags
- OVERFLOW  out  C_NUM_CHANNELS  sticky: increment attempted at max count
- UNDERFLOW  out  C_NUM_CHANNELS  sticky: decrement attempted at zero

Behaviour:
- Clock aclk; reset aresetn, synchronous, active-low.
- Reset values: all counts 0; all FSMs IDLE; all timers 0; IRQ, IRQ_ANY, OVERFLOW and UNDERFLOW all 0.
- Reset wins over every other input in the same cycle. Reset mid-operation discards counts and pending IRQs.
- Per channel i:
  - inc = S_TVALID & S_TREADY & S_TLAST.
  - dec = M_TVALID & M_TREADY & M_TLAST.
- Counter (registered; visible one cycle after the handshake edge):
  - inc & dec: count unchanged, no error.
  - inc only: count+1; at 2^W-1, hold and set OVERFLOW[i].
  - dec only: count-1; at 0, hold 0 and set UNDERFLOW[i].
- CLEAR_ERR clears the error flags. A new error in the same cycle as CLEAR_ERR wins, so the flag stays 1.
- count_next is the value the count takes at the next edge. thr = max(IRQ_THRESHOLD, 1).
- IRQ FSM per channel; states are IDLE, PENDING and ASSERTED. IRQ[i] = (state == ASSERTED), registered.
- IDLE:
  - If ENABLE_IRQ & inc: go to ASSERTED when count_next >= thr or IRQ_TIMEOUT == 1.
  - Otherwise (same condition): go to PENDING and load timer = IRQ_TIMEOUT.
  - Otherwise stay in IDLE.
- PENDING (evaluated in this priority order):
  1. !ENABLE_IRQ -> IDLE.
  2. count_next == 0 (drained by the reader) -> IDLE.
  3. count_next >= thr -> ASSERTED.
  4. IRQ_TIMEOUT != 0 and timer == 1 -> ASSERTED.
  5. Otherwise decrement the timer when it is non-zero.
- PENDING timing rules:
  - The timer is not reloaded by later increments; coalescing is measured from the first packet.
  - Result: ASSERTED exactly IRQ_TIMEOUT cycles after entering PENDING unless the threshold is hit earlier.
- ASSERTED:
  - Holds until CLEAR_IRQ[i], independent of ENABLE_IRQ and the count.
  - On CLEAR_IRQ the IDLE rules are evaluated in the same cycle, so a coincident inc is not lost.
  - Otherwise ASSERTED -> IDLE.
- Illegal state encoding -> IDLE.
- Channels are fully independent; simultaneous events on different channels never interact.
- IRQ_ANY is the registered OR of next-state IRQ bits, so it is cycle-aligned with IRQ.

Optional Feature:
- Macro: PKT_TRACKER_WATERMARK_EN.
- Defined:
  - Adds output AXIS_PACKET_MAX (C_NUM_CHANNELS*C_DATA_COUNT_WIDTH), the per-channel high-watermark of the count.
  - Updates to count_next whenever count_next > current max.
  - Reset to 0; cleared to the current count_next by CLEAR_ERR.
- Not defined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 TLAST beats on S ch0 with ENABLE_IRQ=0 -> AXIS_PACKET_COUNT ch0 = 3 one cycle after the 3rd beat; IRQ = 0.
- Ch1 holds count 5; inc and dec in the same cycle -> count stays 5. Then 6 dec-only cycles -> count 0 and UNDERFLOW[1] = 1. CLEAR_ERR -> UNDERFLOW[1] = 0.
- W=4: 16 inc on ch2 -> count saturates at 15 and OVERFLOW[2] = 1.
- IRQ_THRESHOLD=4, IRQ_TIMEOUT=0, ENABLE ch0: 4 inc -> IRQ[0] and IRQ_ANY = 1 on the edge of the 4th beat. CLEAR_IRQ -> both drop the next cycle.
- IRQ_THRESHOLD=8, IRQ_TIMEOUT=10, one inc on ch3 -> IRQ[3] rises exactly 10 cycles after entering PENDING. Repeat with a dec at cycle 3 -> no IRQ; FSM returns to IDLE.
- ASSERTED ch0; CLEAR_IRQ coincident with inc, IRQ_THRESHOLD=1 -> IRQ[0] stays 1 (re-asserted); aresetn low mid-PENDING -> everything returns to reset values.
